// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ACK,
    DONE
  } state_t;

  localparam logic ECHO   = 1'b0;
  localparam logic RESULT = 1'b1;

  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [7:0] A_UP = 8'h41;
  localparam logic [7:0] CR   = 8'h0D;
  localparam logic [7:0] LF   = 8'h0A;

endpackage

// File: rtl/hex2ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex2ascii
  import tx_sched_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  always_comb begin
    if (nib < 4'd10) ascii = ZERO + {4'b0000, nib};
    else             ascii = A_UP + {4'b0000, nib} - 8'd10;
  end

endmodule

// File: rtl/tx_sched.sv
// Arbitrates echo bytes and hex-formatted result words onto the UART tx byte port.
// Optional CR LF suffix on result messages: define TX_SCHED_CRLF_EN.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              echo_valid,
  input  logic [7:0]        echo_data,
  output logic              echo_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic [7:0]        u_out,
  output logic              u_vaild,
  input  logic              tx_busy
);

  localparam int unsigned ND = DATA_W / 4;
`ifdef TX_SCHED_CRLF_EN
  localparam int unsigned NCHAR = ND + 2;
`else
  localparam int unsigned NCHAR = ND;
`endif
  localparam int unsigned CW = $clog2(NCHAR + 1);

  state_t            state, state_nx;
  logic              last, src;
  logic [7:0]        echo_q;
  logic [DATA_W-1:0] word_q;
  logic [CW-1:0]     cnt, idx;
  logic              grant_echo, grant_res;
  logic [3:0]        nib;
  logic [7:0]        hex_chr, chr;

  // On a tie, the requester not served last wins.
  always_comb begin
    grant_echo = 1'b0;
    grant_res  = 1'b0;
    if (state == IDLE) begin
      if (echo_valid && res_valid) begin
        grant_echo = (last == RESULT);
        grant_res  = (last == ECHO);
      end else begin
        grant_echo = echo_valid;
        grant_res  = res_valid;
      end
    end
  end

  assign echo_ready = grant_echo;
  assign res_ready  = grant_res;

  always_comb begin
    nib = '0;
    for (int unsigned k = 0; k < ND; k++)
      if (idx == CW'(k)) nib = word_q[(ND-1-k)*4 +: 4];
  end

  hex2ascii u_hex2ascii (
    .nib   (nib),
    .ascii (hex_chr)
  );

  always_comb begin
    chr = hex_chr;
    if (src == ECHO) chr = echo_q;
`ifdef TX_SCHED_CRLF_EN
    else if (idx == CW'(ND))     chr = CR;
    else if (idx == CW'(ND + 1)) chr = LF;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    u_vaild  = 1'b0;
    u_out    = '0;
    case (state)
      IDLE: if (grant_echo || grant_res) state_nx = SEND;
      SEND: begin
        u_vaild  = 1'b1;
        u_out    = chr;
        state_nx = ACK;
      end
      ACK:  if (tx_busy) state_nx = DONE;
      DONE: if (!tx_busy) state_nx = (cnt == CW'(1)) ? IDLE : SEND;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last   <= RESULT;
      src    <= RESULT;
      cnt    <= '0;
      idx    <= '0;
      echo_q <= '0;
      word_q <= '0;
    end else if (state == IDLE) begin
      if (grant_echo) begin
        echo_q <= echo_data;
        src    <= ECHO;
        last   <= ECHO;
        cnt    <= CW'(1);
        idx    <= '0;
      end else if (grant_res) begin
        word_q <= res_data;
        src    <= RESULT;
        last   <= RESULT;
        cnt    <= CW'(NCHAR);
        idx    <= '0;
      end
    end else if (state == DONE && !tx_busy) begin
      cnt <= cnt - 1'b1;
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched with a simple tx model holding busy for 10 cycles per byte.
module tb_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        echo_valid = 1'b0;
  logic [7:0]  echo_data = '0;
  logic        echo_ready;
  logic        res_valid = 1'b0;
  logic [15:0] res_data = '0;
  logic        res_ready;
  logic [7:0]  u_out;
  logic        u_vaild;
  logic        tx_busy = 1'b0;

  tx_sched #(.DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .echo_valid (echo_valid),
    .echo_data  (echo_data),
    .echo_ready (echo_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .u_out      (u_out),
    .u_vaild    (u_vaild),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // cyc == k during the cycle after the k-th rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int busy_cnt = 0;
  int fall_edge = 0;
  always @(posedge clk) begin
    if (u_vaild) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 10;
    end else if (tx_busy) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        tx_busy   <= 1'b0;
        fall_edge <= cyc + 1;
      end
    end
  end

  logic [7:0] rx[$];
  int   n_res_hs = 0;
  logic prev_v = 1'b0;
  logic prev_hs = 1'b0;
  always @(negedge clk) begin
    if (u_vaild) begin
      rx.push_back(u_out);
      chk("dbl_strobe", {31'd0, prev_v}, 32'd0);
      // strobe is latched by tx at edge cyc+1, must be two edges after busy fell
      if (!prev_hs) chk("gap", cyc + 1, fall_edge + 2);
    end
    if (res_valid && res_ready) n_res_hs++;
    prev_v  = u_vaild;
    prev_hs = (echo_valid && echo_ready) || (res_valid && res_ready);
  end

  logic [7:0] exp_q[$];

  task automatic add_crlf();
`ifdef TX_SCHED_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic req_echo(input logic [7:0] d);
    int i = 0;
    @(posedge clk); #1;
    echo_data = d; echo_valid = 1'b1; #1;
    while (!echo_ready && i < 3000) begin @(posedge clk); #1; i++; end
    chk("echo_grant", {31'd0, echo_ready}, 32'd1);
    @(posedge clk); #1 echo_valid = 1'b0;
  endtask

  task automatic req_res(input logic [15:0] d);
    int i = 0;
    @(posedge clk); #1;
    res_data = d; res_valid = 1'b1; #1;
    while (!res_ready && i < 3000) begin @(posedge clk); #1; i++; end
    chk("res_grant", {31'd0, res_ready}, 32'd1);
    @(posedge clk); #1 res_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int i = 0;
    while (rx.size() < n && i < 5000) begin @(negedge clk); i++; end
    chk("byte_timeout", rx.size(), n);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_msg(input string tag, input int base);
    chk({tag, "_len"}, rx.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (base + i < rx.size()) ? {24'd0, rx[base+i]} : 32'hDEAD, {24'd0, exp_q[i]});
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int base;
    int hs0;
    int st0;

    do_reset();
    @(negedge clk);
    chk("rst_vaild", {31'd0, u_vaild}, 32'd0);
    chk("rst_out", {24'd0, u_out}, 32'd0);
    chk("rst_eready", {31'd0, echo_ready}, 32'd0);
    chk("rst_rready", {31'd0, res_ready}, 32'd0);

    // basic result message
    base = rx.size(); hs0 = n_res_hs;
    exp_q = {8'h31, 8'h41, 8'h33, 8'h46}; add_crlf();
    req_res(16'h1A3F);
    wait_bytes(base + exp_q.size());
    check_msg("res_1a3f", base);
    chk("res_hs_once", n_res_hs - hs0, 1);

    // ties: echo first after reset, again after a result, result first after an echo
    do_reset();
    base = rx.size();
    exp_q = {8'h65, 8'h30, 8'h30, 8'h30, 8'h30}; add_crlf();
    fork
      req_echo(8'h65);
      req_res(16'h0000);
    join
    wait_bytes(base + exp_q.size());
    check_msg("tie1_0000", base);

    base = rx.size();
    exp_q = {8'h21, 8'h46, 8'h46, 8'h46, 8'h46}; add_crlf();
    fork
      req_echo(8'h21);
      req_res(16'hFFFF);
    join
    wait_bytes(base + exp_q.size());
    check_msg("tie2_ffff", base);

    base = rx.size();
    req_echo(8'h11);
    wait_bytes(base + 1);
    exp_q = {8'h11, 8'h31, 8'h41, 8'h33, 8'h46}; add_crlf(); exp_q.push_back(8'h22);
    fork
      req_echo(8'h22);
      req_res(16'h1A3F);
    join
    wait_bytes(base + exp_q.size());
    check_msg("tie3_alt", base);

    // echo arriving mid-message waits for the whole message
    base = rx.size();
    exp_q = {8'h31, 8'h41, 8'h33, 8'h46}; add_crlf(); exp_q.push_back(8'h35);
    fork
      req_res(16'h1A3F);
      begin repeat (8) @(posedge clk); req_echo(8'h35); end
    join
    wait_bytes(base + exp_q.size());
    check_msg("no_interleave", base);

    // reset during the third char drops the rest of the message
    base = rx.size();
    st0 = 0;
    req_res(16'hBEEF);
    while (rx.size() < base + 3 && st0 < 3000) begin @(negedge clk); st0++; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_vaild", {31'd0, u_vaild}, 32'd0);
    chk("mid_rst_out", {24'd0, u_out}, 32'd0);
    chk("mid_rst_rready", {31'd0, res_ready}, 32'd0);
    repeat (40) @(negedge clk);
    exp_q = {8'h42, 8'h45, 8'h45};
    check_msg("mid_rst_drop", base);

    base = rx.size();
    exp_q = {8'h5A};
    req_echo(8'h5A);
    wait_bytes(base + 1);
    check_msg("post_rst_echo", base);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
